// File: rtl/rda_pkg.sv
// -----------------------------------------------------------------------------
// rda_pkg
// Shared definitions for the RDA sum collector slice.
//   - KPG_K / KPG_P / KPG_G : 8-bit ASCII codes for kill / propagate / generate
//   - RDA_LAT               : default ppc pipeline latency (clock edges)
//   - RDA_DEPTH             : default result FIFO depth
//   - rda_res_t             : one buffered result {sum, cout, err}
//   - kpg_encode()          : per-bit operand pair -> k/p/g code
// -----------------------------------------------------------------------------
package rda_pkg;

  localparam logic [7:0] KPG_K = 8'h6B;  // "k"
  localparam logic [7:0] KPG_P = 8'h70;  // "p"
  localparam logic [7:0] KPG_G = 8'h67;  // "g"

  localparam int RDA_LAT   = 6;
  localparam int RDA_DEPTH = 8;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        err;
  } rda_res_t;

  localparam int RDA_RES_W = $bits(rda_res_t);

  // Both bits set generates a carry, both clear kills it, otherwise the
  // incoming carry is propagated.
  function automatic logic [7:0] kpg_encode(input logic a, input logic b);
    logic [7:0] code;
    if (a && b) begin
      code = KPG_G;
    end else if (!a && !b) begin
      code = KPG_K;
    end else begin
      code = KPG_P;
    end
    return code;
  endfunction

endpackage

// File: rtl/rda_res_fifo.sv
// -----------------------------------------------------------------------------
// rda_res_fifo
// Synchronous first-in/first-out buffer for packed rda_res_t results.
// The head entry is presented combinationally on o_data; a write into an
// empty FIFO therefore becomes visible one cycle later (no bypass path).
// Simultaneous write and read are allowed in every state, including full.
//
// Ports:
//   clk      in  : clock
//   rst      in  : synchronous reset, active low (clears pointers/count)
//   i_wr     in  : push i_data at the next edge
//   i_data   in  : entry to push
//   i_rd     in  : pop the head entry at the next edge (ignored when empty)
//   o_data   out : head entry (undefined contents when empty)
//   o_full   out : DEPTH entries held
//   o_empty  out : no entries held
// -----------------------------------------------------------------------------
module rda_res_fifo
  import rda_pkg::*;
#(
  parameter int DEPTH = RDA_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr,
  input  logic [RDA_RES_W-1:0] i_data,
  input  logic                 i_rd,
  output logic [RDA_RES_W-1:0] o_data,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [RDA_RES_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;

  logic w_do_wr;
  logic w_do_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  // A pop frees a slot in the same edge, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);

  assign o_data = r_mem[r_rd_ptr];

  // Storage array carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + AW'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Upstream credit accounting must make an unmatched push into a full
  // FIFO impossible; losing a result here would be silent otherwise.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(i_wr && o_full && !i_rd));

endmodule

// File: rtl/rda_sum_collector.sv
// -----------------------------------------------------------------------------
// rda_sum_collector
// Issue/collect shell around the RDA prefix pipeline (ppc). Operand pairs are
// encoded into per-bit k/p/g codes for ppc, each issued slot is tracked through
// the fixed ppc latency, and the returned prefix states are turned into a
// 32-bit sum plus carry-out. Results queue in an order-preserving FIFO behind
// a valid/ready port; a credit counter stops issue before the FIFO could
// overflow.
//
// Optional feature macro: RDA_SUM_CHECK_EN
//   defined   : each result carries err = (any prefix state not "k"/"g") or
//               (decoded sum != c + d), presented on out_err.
//   undefined : no checker logic, out_err is constant 0.
//
// Ports:
//   clk        in        : clock, shared with ppc
//   rst        in        : synchronous reset, active low, shared with ppc
//   in_valid   in        : operand pair valid
//   in_ready   out       : operand pair accepted when in_valid && in_ready
//   in_a,in_b  in  [31:0]: addends
//   ppc_x      out [255:0]: per-bit k/p/g codes, bit i at [8*i +: 8]
//   ppc_a,ppc_b out [31:0]: operands carried through ppc
//   ppc_y      in  [255:0]: prefix carry states, bit i at [8*i +: 8]
//   ppc_c,ppc_d in  [31:0]: operands returned from ppc
//   out_valid  out       : result valid
//   out_ready  in        : consumer accepts the result
//   out_sum    out [31:0]: (a + b) mod 2^32
//   out_cout   out       : carry out of bit 31
//   out_err    out       : checker flag (see macro above)
// -----------------------------------------------------------------------------
module rda_sum_collector
  import rda_pkg::*;
#(
  parameter int LAT   = RDA_LAT,
  parameter int DEPTH = RDA_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_a,
  input  logic [31:0]  in_b,
  output logic [255:0] ppc_x,
  output logic [31:0]  ppc_a,
  output logic [31:0]  ppc_b,
  input  logic [255:0] ppc_y,
  input  logic [31:0]  ppc_c,
  input  logic [31:0]  ppc_d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_sum,
  output logic         out_cout,
  output logic         out_err
);

  localparam int OW = $clog2(DEPTH + 1);

  logic           w_in_fire;
  logic           w_out_fire;
  logic [LAT-1:0] r_vsr;
  logic [OW-1:0]  r_occ;

  logic [31:0]    w_gen;
  logic [31:0]    w_sum;
  logic           w_cout;
  logic           w_err;
  rda_res_t       w_wr_res;
  rda_res_t       w_head;
  logic           w_empty;
  logic           w_unused_full;

  // ---------------------------------------------------------------------------
  // Issue side
  // ---------------------------------------------------------------------------
  assign w_in_fire = in_valid && in_ready;

  // Encoding runs every cycle; ppc carries whatever is on the inputs and
  // only slots marked in r_vsr are decoded on the way back.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_enc
      assign ppc_x[8*gi +: 8] = kpg_encode(in_a[gi], in_b[gi]);
    end
  endgenerate

  assign ppc_a = in_a;
  assign ppc_b = in_b;

  // Valid tracker: r_vsr[LAT-1] lines up with the cycle in which
  // ppc_y/c/d hold the result of a fired slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vsr <= '0;
    end else begin
      r_vsr[0] <= w_in_fire;
      for (int i = 1; i < LAT; i++) begin
        r_vsr[i] <= r_vsr[i-1];
      end
    end
  end

  // Credit counter: counts every result from issue until it is popped, so
  // the FIFO always has room for everything still inside ppc.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_occ <= '0;
    end else begin
      case ({w_in_fire, w_out_fire})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Gated by rst so that in_ready is low throughout reset, even on the
  // first cycle before r_occ has been cleared.
  assign in_ready = rst && (r_occ < OW'(DEPTH));

  // ---------------------------------------------------------------------------
  // Collect side
  // ---------------------------------------------------------------------------
  // Prefix state "g" at bit i means a carry leaves bit i.
  generate
    for (gi = 0; gi < 32; gi++) begin : g_dec
      assign w_gen[gi] = (ppc_y[8*gi +: 8] == KPG_G);
    end
  endgenerate

  assign w_sum  = ppc_c ^ ppc_d ^ {w_gen[30:0], 1'b0};
  assign w_cout = w_gen[31];

`ifdef RDA_SUM_CHECK_EN
  logic [31:0] w_bad_state;
  logic [31:0] w_ref_sum;

  // With no carry-in every prefix must have resolved to kill or generate.
  generate
    for (gi = 0; gi < 32; gi++) begin : g_chk
      assign w_bad_state[gi] = !((ppc_y[8*gi +: 8] == KPG_K) ||
                                 (ppc_y[8*gi +: 8] == KPG_G));
    end
  endgenerate

  assign w_ref_sum = ppc_c + ppc_d;
  assign w_err     = (|w_bad_state) || (w_sum != w_ref_sum);
`else
  assign w_err = 1'b0;
`endif

  assign w_wr_res.sum  = w_sum;
  assign w_wr_res.cout = w_cout;
  assign w_wr_res.err  = w_err;

  rda_res_fifo #(
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (r_vsr[LAT-1]),
    .i_data  (w_wr_res),
    .i_rd    (w_out_fire),
    .o_data  (w_head),
    .o_full  (w_unused_full),
    .o_empty (w_empty)
  );

  // ---------------------------------------------------------------------------
  // Result port: zero whenever nothing valid is presented (and during reset).
  // ---------------------------------------------------------------------------
  assign out_valid  = rst && !w_empty;
  assign w_out_fire = out_valid && out_ready;
  assign out_sum    = out_valid ? w_head.sum : '0;
  assign out_cout   = out_valid && w_head.cout;

`ifdef RDA_SUM_CHECK_EN
  assign out_err = out_valid && w_head.err;
`else
  logic w_unused_err;
  assign w_unused_err = w_head.err;
  assign out_err      = 1'b0;
`endif

endmodule

// File: tb/tb_rda_sum_collector.sv
// -----------------------------------------------------------------------------
// tb_rda_sum_collector
// Self-checking bench for rda_sum_collector. A behavioural ppc stands in for
// the real prefix pipeline (carry scan over the k/p/g codes, LAT register
// stages, optional corruption of bit 3 on a chosen slot). Expected results
// come from plain a + b arithmetic kept in an issue-order queue.
// -----------------------------------------------------------------------------
module tb_rda_sum_collector;
  import rda_pkg::*;

  localparam int LAT   = 6;
  localparam int DEPTH = 8;

`ifdef RDA_SUM_CHECK_EN
  localparam logic INJ_ERR = 1'b1;
`else
  localparam logic INJ_ERR = 1'b0;
`endif

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [31:0]  in_a      = '0;
  logic [31:0]  in_b      = '0;
  logic         in_ready;
  logic [255:0] ppc_x;
  logic [31:0]  ppc_a;
  logic [31:0]  ppc_b;
  logic [255:0] ppc_y;
  logic [31:0]  ppc_c;
  logic [31:0]  ppc_d;
  logic         out_valid;
  logic [31:0]  out_sum;
  logic         out_cout;
  logic         out_err;

  always #5 clk = ~clk;

  rda_sum_collector #(
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .ppc_x     (ppc_x),
    .ppc_a     (ppc_a),
    .ppc_b     (ppc_b),
    .ppc_y     (ppc_y),
    .ppc_c     (ppc_c),
    .ppc_d     (ppc_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_err   (out_err)
  );

  // ---------------------------------------------------------------------------
  // Behavioural ppc
  // ---------------------------------------------------------------------------
  logic         inject_now = 1'b0;
  logic [255:0] y_pipe [LAT];
  logic [31:0]  c_pipe [LAT];
  logic [31:0]  d_pipe [LAT];

  function automatic logic [255:0] ppc_scan(input logic [255:0] x, input logic inj);
    logic [255:0] y;
    logic         carry;
    y     = '0;
    carry = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (x[8*i +: 8] == KPG_G) carry = 1'b1;
      else if (x[8*i +: 8] == KPG_K) carry = 1'b0;
      y[8*i +: 8] = carry ? KPG_G : KPG_K;
    end
    if (inj) y[8*3 +: 8] = KPG_P;
    return y;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        y_pipe[i] <= '0;
        c_pipe[i] <= '0;
        d_pipe[i] <= '0;
      end
    end else begin
      y_pipe[0] <= ppc_scan(ppc_x, inject_now);
      c_pipe[0] <= ppc_a;
      d_pipe[0] <= ppc_b;
      for (int i = 1; i < LAT; i++) begin
        y_pipe[i] <= y_pipe[i-1];
        c_pipe[i] <= c_pipe[i-1];
        d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  assign ppc_y = y_pipe[LAT-1];
  assign ppc_c = c_pipe[LAT-1];
  assign ppc_d = d_pipe[LAT-1];

  // ---------------------------------------------------------------------------
  // Reference model and checking
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   last_pop = -100;
  int   pops     = 0;
  bit   consec   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already set: records the transfers that
  // will happen at the coming posedge, then advances to the next negedge.
  task automatic tick();
    exp_t        e;
    logic [32:0] s;
    #1;
    if (in_valid && in_ready) begin
      s      = {1'b0, in_a} + {1'b0, in_b};
      e.sum  = s[31:0];
      e.cout = s[32];
      e.err  = inject_now ? INJ_ERR : 1'b0;
      exp_q.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        $display("result #%0d: sum=%08h cout=%0d err=%0d (expected %08h/%0d/%0d)",
                 pops, out_sum, out_cout, out_err, e.sum, e.cout, e.err);
        chk("sum", out_sum, e.sum);
        chk("cout", out_cout, e.cout);
        chk("err", out_err, e.err);
      end
      if (consec && pops > 0) chk("consecutive", cyc - last_pop, 1);
      last_pop = cyc;
      pops++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int guard;
    guard     = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 60) begin
      tick();
      guard++;
    end
    chk("drain_done", exp_q.size(), 0);
    tick();
    chk("idle_after_drain", out_valid, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_sum"}, out_sum, 32'h0);
    chk({tag, "_out_cout"}, out_cout, 1'b0);
    chk({tag, "_out_err"}, out_err, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  logic [31:0] edge_a [5];
  logic [31:0] edge_b [5];

  initial begin
    int n;
    int acc;
    int seen;

    edge_a = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA};
    edge_b = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h5555_5555};

    // Reset state
    @(negedge clk);
    repeat (3) begin
      #1;
      check_zero_outputs("reset");
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready, 1'b1);

    // Single op 5 + 3, latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'd5;
    in_b      = 32'd3;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, 6);
    chk("first_sum", out_sum, 32'd8);
    drain();

    // Carry boundary cases, back to back
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = edge_a[i];
      in_b     = edge_b[i];
      tick();
    end
    drain();

    // 16 random back-to-back ops with out_ready high
    consec = 1'b1;
    pops   = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_a     = $urandom;
      in_b     = $urandom;
      chk("b2b_in_ready", in_ready, 1'b1);
      tick();
    end
    drain();
    chk("b2b_count", pops, 16);
    consec = 1'b0;

    // Backpressure: exactly DEPTH accepted, outputs hold
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc       = 0;
    for (int i = 0; i < 14; i++) begin
      in_a = $urandom;
      in_b = $urandom;
      if (in_ready) acc++;
      tick();
    end
    chk("bp_accepted", acc, DEPTH);
    chk("bp_in_ready_low", in_ready, 1'b0);
    for (int i = 0; i < 20; i++) begin
      in_a = $urandom;
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_sum", out_sum, exp_q[0].sum);
      chk("bp_hold_cout", out_cout, exp_q[0].cout);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pulse_in_ready", in_ready, 1'b1);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      in_a = $urandom;
      in_b = $urandom;
      if (in_ready) acc++;
      tick();
    end
    chk("pulse_one_more", acc, 1);
    chk("pulse_in_ready_low", in_ready, 1'b0);
    drain();

    // Reset with 2 buffered and 3 in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) begin
      in_a = $urandom;
      in_b = $urandom;
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    in_valid = 1'b1;
    repeat (3) begin
      in_a = $urandom;
      in_b = $urandom;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", out_valid, 1'b1);
    rst = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    exp_q.delete();
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    repeat (15) begin
      if (out_valid) seen++;
      tick();
    end
    chk("no_stale_results", seen, 0);
    in_valid = 1'b1;
    in_a     = $urandom;
    in_b     = $urandom;
    tick();
    drain();

    // Corrupted prefix state on one slot, clean neighbours
    in_valid = 1'b1;
    in_a     = $urandom;
    in_b     = $urandom;
    tick();
    in_a       = 32'd5;
    in_b       = 32'd3;
    inject_now = 1'b1;
    tick();
    inject_now = 1'b0;
    in_a       = $urandom;
    in_b       = $urandom;
    tick();
    drain();

    // Random valid/ready traffic
    for (int i = 0; i < 200; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a      = $urandom;
      in_b      = $urandom;
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
